instr_register_reader: RTL and testbench

Hardware reader/executor for the instruction register: it sweeps the register's read port over a programmed range of entries and evaluates each stored instruction (opcode, operand_a, operand_b). It streams one signed result per entry to a downstream consumer through a valid/ready handshake. It sits on the read side of the instruction register, opposite the write-side stimulus that loads entries through load_en/write_pointer.

---
 rtl/instr_register_reader.sv | 204 ++++++++++++++++++++
 tb/tb_instr_register_reader.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_register_reader.sv
// instr_register_reader: walks the instruction register read port over a
// programmed range of entries, evaluates each stored instruction and streams
// one signed result per entry to a valid/ready consumer.
module instr_register_reader #(
  parameter int NUM_ENTRIES = 32,
  parameter int ADDR_W      = 5,
  parameter int OP_W        = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [ADDR_W-1:0]          first_ptr,
  input  logic [ADDR_W:0]            count,
  output logic [ADDR_W-1:0]          read_pointer,
  input  logic [3:0]                 instr_opcode,
  input  logic signed [OP_W-1:0]     instr_operand_a,
  input  logic signed [OP_W-1:0]     instr_operand_b,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [ADDR_W-1:0]          res_pointer,
  output logic [3:0]                 res_opcode,
  output logic signed [2*OP_W-1:0]   res_result,
  output logic                       res_div0,
  output logic                       res_illegal,
  output logic                       busy,
  output logic                       done
);

  localparam int RES_W = 2 * OP_W;

  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);
  localparam logic [ADDR_W:0]   REM_ONE   = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0]   MAX_COUNT = (ADDR_W + 1)'(NUM_ENTRIES);
  localparam logic signed [RES_W-1:0] RES_ONE = RES_W'(1);

  localparam logic [3:0] OP_ZERO  = 4'd0;
  localparam logic [3:0] OP_PASSA = 4'd1;
  localparam logic [3:0] OP_PASSB = 4'd2;
  localparam logic [3:0] OP_ADD   = 4'd3;
  localparam logic [3:0] OP_SUB   = 4'd4;
  localparam logic [3:0] OP_MULT  = 4'd5;
  localparam logic [3:0] OP_DIV   = 4'd6;
  localparam logic [3:0] OP_MOD   = 4'd7;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    EXEC  = 3'd2,
    OUT   = 3'd3,
    FIN   = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W:0]   remaining_q;

  logic [3:0]              op_p0;
  logic signed [OP_W-1:0]  a_p0;
  logic signed [OP_W-1:0]  b_p0;

  logic signed [RES_W-1:0] a_ext_p1;
  logic signed [RES_W-1:0] b_ext_p1;
  logic signed [RES_W-1:0] b_safe_p1;
  logic                    b_zero_p1;
  logic signed [RES_W-1:0] result_p1;
  logic                    div0_p1;
  logic                    illegal_p1;

  // Requests larger than the register are saturated to one full sweep.
  function automatic logic [ADDR_W:0] clamp_count(input logic [ADDR_W:0] c);
    return (c > MAX_COUNT) ? MAX_COUNT : c;
  endfunction

  // Operands are widened to the result width so every opcode is exact.
  function automatic logic signed [RES_W-1:0] sext_op(input logic signed [OP_W-1:0] v);
    return {{OP_W{v[OP_W-1]}}, v};
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode and handshake/status outputs.
  always_comb begin
    state_d   = state_q;
    res_valid = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_d = (count == '0) ? FIN : FETCH;
        end
      end
      FETCH: state_d = EXEC;
      EXEC:  state_d = OUT;
      OUT: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_d = (remaining_q == REM_ONE) ? FIN : FETCH;
        end
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Range bookkeeping: current pointer, entries left, and the read address.
  // read_pointer only moves when the next state is FETCH, so it holds its
  // last value everywhere else (including after the final beat).
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q        <= '0;
      remaining_q  <= '0;
      read_pointer <= '0;
    end else begin
      if (state_q == IDLE && start) begin
        ptr_q       <= first_ptr;
        remaining_q <= clamp_count(count);
        if (count != '0) begin
          read_pointer <= first_ptr;
        end
      end
      if (state_q == OUT && res_ready) begin
        ptr_q       <= ptr_q + PTR_ONE;
        remaining_q <= remaining_q - REM_ONE;
        if (remaining_q != REM_ONE) begin
          read_pointer <= ptr_q + PTR_ONE;
        end
      end
    end
  end

  // ---- stage p0: capture the addressed entry during FETCH ----
  always_ff @(posedge clk) begin
    if (state_q == FETCH) begin
      op_p0 <= instr_opcode;
      a_p0  <= instr_operand_a;
      b_p0  <= instr_operand_b;
    end
  end

  // ---- stage p1: evaluate the captured instruction ----
  always_comb begin
    a_ext_p1   = sext_op(a_p0);
    b_ext_p1   = sext_op(b_p0);
    b_zero_p1  = (b_p0 == '0);
    b_safe_p1  = b_zero_p1 ? RES_ONE : b_ext_p1;
    result_p1  = '0;
    div0_p1    = 1'b0;
    illegal_p1 = 1'b0;
    case (op_p0)
      OP_ZERO:  result_p1 = '0;
      OP_PASSA: result_p1 = a_ext_p1;
      OP_PASSB: result_p1 = b_ext_p1;
      OP_ADD:   result_p1 = a_ext_p1 + b_ext_p1;
      OP_SUB:   result_p1 = a_ext_p1 - b_ext_p1;
      OP_MULT:  result_p1 = a_ext_p1 * b_ext_p1;
      OP_DIV: begin
        if (b_zero_p1) begin
          div0_p1 = 1'b1;
        end else begin
          result_p1 = a_ext_p1 / b_safe_p1;
        end
      end
      OP_MOD: begin
        if (b_zero_p1) begin
          div0_p1 = 1'b1;
        end else begin
          result_p1 = a_ext_p1 % b_safe_p1;
        end
      end
      default: illegal_p1 = 1'b1;
    endcase
  end

  // ---- stage p2: result beat register, loaded in EXEC, held through OUT ----
  always_ff @(posedge clk) begin
    if (reset) begin
      res_pointer <= '0;
      res_opcode  <= '0;
      res_result  <= '0;
      res_div0    <= 1'b0;
      res_illegal <= 1'b0;
    end else if (state_q == EXEC) begin
      res_pointer <= ptr_q;
      res_opcode  <= op_p0;
      res_result  <= result_p1;
      res_div0    <= div0_p1;
      res_illegal <= illegal_p1;
    end
  end

endmodule

// File: tb/tb_instr_register_reader.sv
// Testbench for instr_register_reader: an array-backed instruction register,
// a table of hand-computed vectors, directed corner sequences and randomized
// sweeps checked against an arithmetic reference model.
module tb_instr_register_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [4:0]  first_ptr;
  logic [5:0]  count;
  logic [4:0]  read_pointer;
  logic [3:0]  instr_opcode;
  logic [31:0] instr_operand_a;
  logic [31:0] instr_operand_b;
  logic        res_valid;
  logic        res_ready;
  logic [4:0]  res_pointer;
  logic [3:0]  res_opcode;
  logic [63:0] res_result;
  logic        res_div0;
  logic        res_illegal;
  logic        busy;
  logic        done;

  logic [3:0] mem_op [32];
  int         mem_a  [32];
  int         mem_b  [32];

  assign instr_opcode    = mem_op[read_pointer];
  assign instr_operand_a = mem_a[read_pointer];
  assign instr_operand_b = mem_b[read_pointer];

  instr_register_reader dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .first_ptr       (first_ptr),
    .count           (count),
    .read_pointer    (read_pointer),
    .instr_opcode    (instr_opcode),
    .instr_operand_a (instr_operand_a),
    .instr_operand_b (instr_operand_b),
    .res_valid       (res_valid),
    .res_ready       (res_ready),
    .res_pointer     (res_pointer),
    .res_opcode      (res_opcode),
    .res_result      (res_result),
    .res_div0        (res_div0),
    .res_illegal     (res_illegal),
    .busy            (busy),
    .done            (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int     ptr;
    int     op;
    longint result;
    bit     div0;
    bit     ill;
  } beat_t;

  typedef struct {
    logic [3:0] op;
    int         a;
    int         b;
    longint     res;
    bit         div0;
    bit         ill;
  } vec_t;

  int    n_tests = 0;
  int    n_fail  = 0;
  beat_t obs[$];
  vec_t  tbl[16];

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Reference: what the spec says entry idx must produce.
  function automatic beat_t model(input int idx);
    beat_t  b;
    longint x;
    longint y;
    x = mem_a[idx];
    y = mem_b[idx];
    b.ptr = idx; b.op = int'(mem_op[idx]); b.result = 0; b.div0 = 0; b.ill = 0;
    case (mem_op[idx])
      4'd0: b.result = 0;
      4'd1: b.result = x;
      4'd2: b.result = y;
      4'd3: b.result = x + y;
      4'd4: b.result = x - y;
      4'd5: b.result = x * y;
      4'd6: if (y == 0) b.div0 = 1; else b.result = x / y;
      4'd7: if (y == 0) b.div0 = 1; else b.result = x % y;
      default: b.ill = 1;
    endcase
    return b;
  endfunction

  function automatic int rand_operand();
    case ($urandom_range(0, 7))
      0: return int'(32'h8000_0000);
      1: return -1;
      2: return 0;
      3: return int'(32'h7fff_ffff);
      4: return int'($urandom_range(0, 20)) - 10;
      default: return int'($urandom);
    endcase
  endfunction

  task automatic fill_random();
    for (int i = 0; i < 32; i++) begin
      mem_op[i] = 4'($urandom_range(0, 15));
      mem_a[i]  = rand_operand();
      mem_b[i]  = rand_operand();
    end
  endtask

  // One start/sweep. mode 0: ready always high; 1: random ready;
  // 2: ready held low for 5 cycles on the 2nd beat. poke pulses a stray
  // start mid-run with a different range.
  task automatic run(input int fp, input int cnt, input int mode, input bit poke);
    int    k, first_k, done_k, done_n, last_acc, beat_n, hold, n;
    bit    pend, fin, rdy;
    beat_t cur, prev, e, g;
    first_k = -1; done_k = -1; done_n = 0; last_acc = -1; beat_n = 0; hold = 0;
    pend = 0; fin = 0;
    prev = '{0, 0, 0, 0, 0};
    obs.delete();
    first_ptr = 5'(fp); count = 6'(cnt); start = 1'b1; res_ready = 1'b1;
    @(negedge clk);
    start = 1'b0; k = 1;
    if (cnt != 0) check("read_pointer_after_start", read_pointer, fp);
    check("busy_after_start", busy, 1);
    while (!fin && k < 1500) begin
      cur.ptr = int'(res_pointer); cur.op = int'(res_opcode);
      cur.result = $signed(res_result); cur.div0 = res_div0; cur.ill = res_illegal;
      if (pend) begin
        check("stall_valid", res_valid, 1);
        check("stall_ptr", cur.ptr, prev.ptr);
        check("stall_op", cur.op, prev.op);
        check("stall_result", cur.result, prev.result);
        check("stall_flags", {cur.div0, cur.ill}, {prev.div0, prev.ill});
      end
      if (res_valid && first_k < 0) first_k = k;
      if (done) begin done_n++; done_k = k; end
      if (done_k >= 0 && k == done_k + 1) begin
        check("busy_after_done", busy, 0);
        check("done_single_cycle", done, 0);
        fin = 1;
      end else begin
        rdy = 1'b1;
        if (mode == 1) rdy = ($urandom_range(0, 3) != 0);
        if (mode == 2 && res_valid && beat_n == 1 && hold < 5) begin rdy = 1'b0; hold++; end
        res_ready = rdy;
        if (poke && k == 4) begin start = 1'b1; first_ptr = 5'(fp + 9); count = 6'd3; end
        else start = 1'b0;
        pend = res_valid && !rdy;
        prev = cur;
        if (res_valid && rdy) begin obs.push_back(cur); last_acc = k; beat_n++; end
        @(negedge clk);
        k++;
      end
    end
    start = 1'b0; res_ready = 1'b1;
    if (!fin) check("run_timeout", 1, 0);
    n = (cnt > 32) ? 32 : cnt;
    check("beat_count", obs.size(), n);
    check("done_pulses", done_n, 1);
    if (cnt == 0) begin
      check("done_latency_empty", done_k, 1);
    end else begin
      check("first_valid_latency", first_k, 3);
      check("done_after_last_beat", done_k, last_acc + 1);
      if (mode == 0) check("throughput_last_beat", last_acc, 3 * n);
    end
    for (int i = 0; i < n; i++) begin
      e = model((fp + i) % 32);
      g = (i < obs.size()) ? obs[i] : '{-1, -1, 0, 0, 0};
      check("beat_ptr", g.ptr, e.ptr);
      check("beat_op", g.op, e.op);
      check("beat_result", g.result, e.result);
      check("beat_div0", g.div0, e.div0);
      check("beat_illegal", g.ill, e.ill);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_read_pointer"}, read_pointer, 0);
    check({tag, "_res_valid"}, res_valid, 0);
    check({tag, "_res_pointer"}, res_pointer, 0);
    check({tag, "_res_opcode"}, res_opcode, 0);
    check({tag, "_res_result"}, res_result, 0);
    check({tag, "_flags"}, {res_div0, res_illegal}, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  initial begin
    bit seen;
    int w;

    tbl[0]  = '{4'd3,  5,    3,  8,   0, 0};
    tbl[1]  = '{4'd4,  5,    8,  -3,  0, 0};
    tbl[2]  = '{4'd5,  -7,   6,  -42, 0, 0};
    tbl[3]  = '{4'd2,  0,    9,  9,   0, 0};
    tbl[4]  = '{4'd6,  -7,   2,  -3,  0, 0};
    tbl[5]  = '{4'd7,  -7,   2,  -1,  0, 0};
    tbl[6]  = '{4'd6,  9,    0,  0,   1, 0};
    tbl[7]  = '{4'd7,  9,    0,  0,   1, 0};
    tbl[8]  = '{4'd12, 4,    4,  0,   0, 1};
    tbl[9]  = '{4'd5,  int'(32'h8000_0000), int'(32'h8000_0000), 64'sh4000_0000_0000_0000, 0, 0};
    tbl[10] = '{4'd6,  int'(32'h8000_0000), -1, 64'sd2147483648, 0, 0};
    tbl[11] = '{4'd1,  -123, 77, -123, 0, 0};
    tbl[12] = '{4'd0,  11,   22, 0,   0, 0};
    tbl[13] = '{4'd7,  7,    -3, 1,   0, 0};
    tbl[14] = '{4'd6,  7,    -2, -3,  0, 0};
    tbl[15] = '{4'd8,  1,    1,  0,   0, 1};

    reset = 1'b1; start = 1'b0; res_ready = 1'b1; first_ptr = '0; count = '0;
    fill_random();
    @(negedge clk); @(negedge clk);
    check_reset_values("reset");
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      mem_op[i] = tbl[i].op; mem_a[i] = tbl[i].a; mem_b[i] = tbl[i].b;
    end

    // Basic sweep over the first four entries with ready held high.
    run(0, 4, 0, 0);

    // Whole table with random backpressure, compared to hand-computed values.
    run(0, 16, 1, 0);
    for (int i = 0; i < 16; i++) begin
      beat_t g;
      g = (i < obs.size()) ? obs[i] : '{-1, -1, 0, 0, 0};
      check("tbl_ptr", g.ptr, i);
      check("tbl_result", g.result, tbl[i].res);
      check("tbl_div0", g.div0, tbl[i].div0);
      check("tbl_illegal", g.ill, tbl[i].ill);
    end

    // Wrap across the end of the register.
    run(30, 3, 0, 0);
    check("wrap_ptr0", (obs.size() > 0) ? obs[0].ptr : -1, 30);
    check("wrap_ptr1", (obs.size() > 1) ? obs[1].ptr : -1, 31);
    check("wrap_ptr2", (obs.size() > 2) ? obs[2].ptr : -1, 0);

    // Oversized count saturates to one full sweep; zero count emits nothing.
    run(3, 40, 1, 0);
    check("saturated_beats", obs.size(), 32);
    run(5, 0, 0, 0);

    // Backpressure on the second beat, then a stray start while busy.
    run(0, 6, 2, 0);
    run(1, 5, 0, 1);

    // Reset while a beat is waiting in OUT.
    first_ptr = 5'd2; count = 6'd4; res_ready = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    w = 0;
    while (!res_valid && w < 10) begin @(negedge clk); w++; end
    check("reset_test_reached_out", res_valid, 1);
    reset = 1'b1;
    @(negedge clk);
    check_reset_values("midrun_reset");
    reset = 1'b0; res_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done || res_valid || busy) seen = 1;
    end
    check("no_activity_after_reset", seen, 0);

    // Randomized sweeps against the reference model.
    for (int it = 0; it < 10; it++) begin
      int c;
      fill_random();
      c = $urandom_range(0, 40);
      run($urandom_range(0, 31), c, $urandom_range(0, 2), (c >= 2) && ($urandom_range(0, 1) == 1));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
